// File: rtl/note_sequencer.sv
// Song sequencer: walks a song ROM and hands {note, duration} pairs to note_player.
// Optional build macro NOTE_SEQ_LOOP_EN makes the song repeat instead of stopping in DONE.
module note_sequencer #(
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play_enable,
  input  logic                     new_song,
  input  logic [SONG_W-1:0]        song_sel,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [11:0]              rom_data,
  output logic [5:0]               note_to_load,
  output logic [5:0]               duration_to_load,
  output logic                     load_new_note,
  input  logic                     done_with_note,
  output logic                     song_done
);

  // state   | meaning
  // IDLE    | after reset, waiting for play_enable
  // FETCH   | rom_addr presented, ROM registering the entry
  // WAIT    | rom_data valid, captured; end marker checked
  // LOAD    | load_new_note pulse to note_player
  // PLAYING | note sounding, waiting for done_with_note
  // DONE    | song finished, only new_song leaves
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, PLAYING, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

  state_t              state, state_next;
  logic [SONG_W-1:0]   song;
  logic [ADDR_W-1:0]   index;
  logic                capture;
  logic                index_inc;
  logic                end_hit;

  assign rom_addr = {song, index};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    index_inc     = 1'b0;
    end_hit       = 1'b0;
    load_new_note = 1'b0;
    if (new_song) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    if (play_enable) state_next = FETCH;
        FETCH:   if (play_enable) state_next = WAIT;
        WAIT: begin
          if (play_enable) begin
            capture = 1'b1;
            if (rom_data[5:0] != 6'd0) state_next = LOAD;
            else                       end_hit    = 1'b1;
          end
        end
        LOAD: begin
          if (play_enable) begin
            load_new_note = 1'b1;
            state_next    = PLAYING;
          end
        end
        PLAYING: begin
          // PLAYING advances even when paused; the stall happens in FETCH.
          if (done_with_note) begin
            if (index == LAST_INDEX) begin
              end_hit = 1'b1;
            end else begin
              index_inc  = 1'b1;
              state_next = FETCH;
            end
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
`ifdef NOTE_SEQ_LOOP_EN
      if (end_hit) state_next = FETCH;
`else
      if (end_hit) state_next = DONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song             <= '0;
      index            <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      song_done        <= 1'b0;
    end else if (new_song) begin
      song      <= song_sel;
      index     <= '0;
      song_done <= 1'b0;
    end else begin
      if (capture) begin
        note_to_load     <= rom_data[11:6];
        duration_to_load <= rom_data[5:0];
      end
      if (index_inc) index <= index + 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
      if (end_hit) index <= '0;
      song_done <= end_hit;
`else
      if (end_hit) song_done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a registered song ROM model.
// Loop-mode expectations are selected when NOTE_SEQ_LOOP_EN is defined.
module tb_note_sequencer;

  localparam int SONG_W = 2;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     play_enable;
  logic                     new_song;
  logic [SONG_W-1:0]        song_sel;
  logic [SONG_W+ADDR_W-1:0] rom_addr;
  logic [11:0]              rom_data;
  logic [5:0]               note_to_load;
  logic [5:0]               duration_to_load;
  logic                     load_new_note;
  logic                     done_with_note;
  logic                     song_done;

  logic [11:0] rom [0:127];
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  note_sequencer #(.SONG_W(SONG_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .play_enable      (play_enable),
    .new_song         (new_song),
    .song_sel         (song_sel),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .done_with_note   (done_with_note),
    .song_done        (song_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts rising edges until load_new_note is seen at a falling edge; single-cycle
  // inputs are dropped after the first edge.
  task automatic wait_load(input int max, output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < max) begin
      @(posedge clk);
      n++;
      #1;
      done_with_note = 1'b0;
      new_song       = 1'b0;
      @(negedge clk);
      if (load_new_note) seen = 1;
    end
  endtask

  initial begin
    int n;
    int loads;

    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[0]  = {6'd57, 6'd5};
    rom[1]  = {6'd1,  6'd8};
    rom[2]  = {6'd0,  6'd0};
    for (int i = 0; i < 32; i++) rom[32+i] = {6'(i + 20), 6'(i % 7 + 1)};
    rom[64] = {6'd10, 6'd3};
    rom[65] = {6'd0,  6'd0};

    rst_n = 1'b0;
    play_enable = 1'b0;
    new_song = 1'b0;
    song_sel = '0;
    done_with_note = 1'b0;
    #12;
    check_val("rst_rom_addr", 32'(rom_addr), 0);
    check_val("rst_note", 32'(note_to_load), 0);
    check_val("rst_dur", 32'(duration_to_load), 0);
    check_val("rst_load", 32'(load_new_note), 0);
    check_val("rst_song_done", 32'(song_done), 0);

    // song 0 from IDLE
    @(negedge clk);
    rst_n = 1'b1;
    play_enable = 1'b1;
    wait_load(10, n);
    check_val("start_latency", n, 3);
    check_val("e0_note", 32'(note_to_load), 57);
    check_val("e0_dur", 32'(duration_to_load), 5);
    @(negedge clk);
    check_val("load_one_cycle", 32'(load_new_note), 0);
    done_with_note = 1'b1;
    wait_load(10, n);
    check_val("next_latency", n, 3);
    check_val("e1_note", 32'(note_to_load), 1);
    check_val("e1_dur", 32'(duration_to_load), 8);
    @(negedge clk);
    done_with_note = 1'b1;
    @(posedge clk);
    #1 done_with_note = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef NOTE_SEQ_LOOP_EN
    check_val("wrap_song_done", 32'(song_done), 1);
    check_val("wrap_rom_addr", 32'(rom_addr), 0);
    wait_load(10, n);
    check_val("wrap_latency", n, 2);
    check_val("wrap_note", 32'(note_to_load), 57);
    check_val("wrap_dur", 32'(duration_to_load), 5);
    check_val("wrap_song_done_pulse", 32'(song_done), 0);
`else
    check_val("end_song_done", 32'(song_done), 1);
    check_val("end_rom_addr", 32'(rom_addr), 2);
    loads = 0;
    done_with_note = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1 done_with_note = 1'b0;
      @(negedge clk);
      loads += int'(load_new_note);
    end
    check_val("done_no_load", loads, 0);
    check_val("done_holds", 32'(song_done), 1);
    check_val("done_rom_addr", 32'(rom_addr), 2);
`endif

    // pause: done while paused parks in FETCH
    song_sel = 2'd0;
    new_song = 1'b1;
    wait_load(10, n);
    check_val("restart_latency", n, 3);
    check_val("restart_song_done", 32'(song_done), 0);
    @(negedge clk);
    play_enable = 1'b0;
    done_with_note = 1'b1;
    loads = 0;
    repeat (5) begin
      @(posedge clk);
      #1 done_with_note = 1'b0;
      @(negedge clk);
      loads += int'(load_new_note);
    end
    check_val("pause_no_load", loads, 0);
    check_val("pause_rom_addr", 32'(rom_addr), 1);
    play_enable = 1'b1;
    wait_load(10, n);
    check_val("resume_latency", n, 2);
    check_val("resume_note", 32'(note_to_load), 1);
    check_val("resume_dur", 32'(duration_to_load), 8);

    // new_song to song 2 during PLAYING
    @(negedge clk);
    song_sel = 2'd2;
    new_song = 1'b1;
    @(posedge clk);
    #1 new_song = 1'b0;
    @(negedge clk);
    check_val("ns_rom_addr", 32'(rom_addr), 64);
    check_val("ns_song_done", 32'(song_done), 0);
    wait_load(10, n);
    check_val("ns_latency", n, 2);
    check_val("ns_note", 32'(note_to_load), 10);
    check_val("ns_dur", 32'(duration_to_load), 3);

    // song 1: 32 entries with no end marker
    @(negedge clk);
    song_sel = 2'd1;
    new_song = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_load(10, n);
      check_val($sformatf("s1_latency_%0d", i), n, 3);
      check_val($sformatf("s1_note_%0d", i), 32'(note_to_load), i + 20);
      check_val($sformatf("s1_dur_%0d", i), 32'(duration_to_load), i % 7 + 1);
      @(negedge clk);
      done_with_note = 1'b1;
    end
    @(posedge clk);
    #1 done_with_note = 1'b0;
    @(negedge clk);
`ifdef NOTE_SEQ_LOOP_EN
    check_val("s1_wrap_song_done", 32'(song_done), 1);
    check_val("s1_wrap_rom_addr", 32'(rom_addr), 32);
    wait_load(10, n);
    check_val("s1_wrap_latency", n, 2);
    check_val("s1_wrap_note", 32'(note_to_load), 20);
`else
    check_val("s1_song_done", 32'(song_done), 1);
    check_val("s1_rom_addr", 32'(rom_addr), 63);
    check_val("s1_no_load", 32'(load_new_note), 0);
`endif

    // async reset during LOAD
    @(negedge clk);
    song_sel = 2'd0;
    new_song = 1'b1;
    wait_load(10, n);
    check_val("pre_reset_load", 32'(load_new_note), 1);
    rst_n = 1'b0;
    #1;
    check_val("ar_load", 32'(load_new_note), 0);
    check_val("ar_rom_addr", 32'(rom_addr), 0);
    check_val("ar_note", 32'(note_to_load), 0);
    check_val("ar_dur", 32'(duration_to_load), 0);
    check_val("ar_song_done", 32'(song_done), 0);
    @(negedge clk);
    check_val("ar_hold_load", 32'(load_new_note), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
